// File: rtl/hps_debug_pio_poller.sv
// Avalon-MM read master that polls one register of a fixed-latency PIO slave on a timer or
// on request, and reports each result as a one-cycle strobe with change detection.
module hps_debug_pio_poller #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int POLL_PERIOD  = 1000,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              poll_now,
  input  logic [ADDR_W-1:0] cfg_address,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              sample_changed,
  output logic [15:0]       sample_count,
  output logic              busy,
  output logic              timeout_err
);
  localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] RELOAD   = PW'(POLL_PERIOD - 1);
  localparam logic [7:0]    WAIT_MAX = 8'(TIMEOUT - 1);
  localparam logic [2:0]    LAT_INIT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     period_q, period_d;
  logic              pending_q, pending_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        lat_q, lat_d;
  logic [7:0]        wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              changed_q, changed_d;
  logic [15:0]       sample_count_q, sample_count_d;
  logic              err_q, err_d;
  logic              expire, trigger, err_set;

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    pending_d      = pending_q;
    first_d        = first_q;
    addr_d         = addr_q;
    lat_d          = lat_q;
    wait_d         = wait_q;
    data_d         = data_q;
    valid_d        = 1'b0;
    changed_d      = 1'b0;
    sample_count_d = sample_count_q;
    expire         = 1'b0;
    err_set        = 1'b0;

    if (!enable) begin
      period_d  = RELOAD;
      pending_d = 1'b0;
    end else if (period_q == '0) begin
      period_d = RELOAD;
      expire   = 1'b1;
    end else begin
      period_d = period_q - 1'b1;
    end
    trigger = enable && (expire || poll_now);

    // Triggers that arrive while a read is in flight collapse into one deferred poll
    if (trigger && state_q != IDLE) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          state_d   = REQ;
          addr_d    = cfg_address;
          pending_d = 1'b0;
          wait_d    = '0;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
          wait_d  = '0;
        end else if (wait_q == WAIT_MAX) begin
          state_d = IDLE;
          err_set = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WAIT: begin
        if (lat_q == 3'd1) begin
          state_d        = IDLE;
          data_d         = avm_readdata;
          valid_d        = 1'b1;
          changed_d      = (avm_readdata != data_q) || first_q;
          first_d        = 1'b0;
          sample_count_d = sample_count_q + 16'd1;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A timeout in the same cycle as clear_err must stay visible
    if (err_set)        err_d = 1'b1;
    else if (clear_err) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      period_q       <= RELOAD;
      pending_q      <= 1'b0;
      first_q        <= 1'b1;
      addr_q         <= '0;
      lat_q          <= '0;
      wait_q         <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      changed_q      <= 1'b0;
      sample_count_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      pending_q      <= pending_d;
      first_q        <= first_d;
      addr_q         <= addr_d;
      lat_q          <= lat_d;
      wait_q         <= wait_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      changed_q      <= changed_d;
      sample_count_q <= sample_count_d;
      err_q          <= err_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = (state_q == REQ);
  assign busy           = (state_q != IDLE);
  assign sample_data    = data_q;
  assign sample_valid   = valid_q;
  assign sample_changed = changed_q;
  assign sample_count   = sample_count_q;
  assign timeout_err    = err_q;

endmodule
